histogram_cdf_unit: RTL
=======================

// Module: histogram_cdf_unit
// PURPOSE
//  Parametrised histogram/CDF engine for the memory stage of the SIMD pipeline. It replaces the
//  fixed pair of 256x16 histogram banks and the combinational accumulator with NUM_HIST banks,
//  each holding a histogram array and a CDF array. Histograms are cleared, filled from LANES-wide
//  pixel vectors, and scanned into a saturating running-sum CDF under a sequential FSM.
//  Results are read back through a registered port that feeds the memory-stage output mux.
// PARAMETERS
//  LANES     16   pixels per input vector (pix_data width = LANES*PIX_W)
//  PIX_W     8    bits per pixel; BINS = 2**PIX_W
//  CNT_W     16   bits per histogram/CDF entry
//  NUM_HIST  2    number of independent banks; BSEL_W = max(1,$clog2(NUM_HIST))
// PORTS
//  clk          in   1              clock, all state on rising edge
//  reset        in   1              asynchronous, active-low reset
//  bank_sel     in   BSEL_W         target bank for clear_start/cdf_start/pixel vector
//  clear_start  in   1              request zeroing of hist+cdf arrays of bank_sel
//  cdf_start    in   1              request CDF scan of bank_sel
//  pix_valid    in   1              pixel vector present on pix_data
//  pix_ready    out  1              vector accepted when pix_valid & pix_ready
//  pix_data     in   LANES*PIX_W    lane i = pix_data[i*PIX_W +: PIX_W]
//  rd_en        in   1              read request
//  rd_src       in   1              0 = histogram array, 1 = CDF array
//  rd_bank      in   BSEL_W         bank to read
//  rd_addr      in   PIX_W          bin to read
//  rd_data      out  CNT_W          read result (registered)
//  rd_valid     out  1              rd_data valid this cycle
//  busy         out  1              FSM not in IDLE
//  done         out  1              one-cycle pulse when CLEAR, ACCUM or CDF completes
// BEHAVIOUR
//  - Reset: FSM=IDLE, pix_ready=1, busy=0, done=0, rd_valid=0, rd_data=0, counters=0.
//    Array contents are NOT reset; software issues clear_start before use.
//  - States: IDLE, CLEAR, ACCUM, CDF. Commands are sampled only in IDLE and ignored while busy.
//  - IDLE priority on simultaneous requests: clear_start > cdf_start > pix_valid.
//    The selected bank is latched on entry. pix_ready = (state==IDLE) & ~clear_start & ~cdf_start.
//  - CLEAR: BINS cycles, bin index 0..BINS-1; writes 0 to hist[b][idx] and cdf[b][idx].
//    Pulses done on the cycle of the last write, then returns to IDLE.
//  - ACCUM: the vector is latched on acceptance. LANES cycles, lane 0 first, each doing
//    hist[b][lane_pix]++. Increments saturate at 2**CNT_W-1 (no wrap). Duplicate pixel values
//    across lanes must each count; the read-modify-write forwards the previous lane's result.
//    Pulses done on the last lane, then IDLE. Throughput is one vector per LANES+1 cycles.
//  - CDF: BINS cycles, idx ascending; sum = sat(sum + hist[b][idx]); cdf[b][idx] = sum.
//    The running sum starts at 0 each scan and saturates at 2**CNT_W-1.
//    Pulses done on the last write, then IDLE. Histogram is unchanged.
//  - Read port is independent of the FSM and always serviced. rd_valid/rd_data appear the cycle
//    after rd_en (1-cycle latency). rd_valid=0 when rd_en was 0; rd_data then holds its value.
//    A read of an entry written in the same cycle returns the old value.
//  - Out-of-range bank_sel/rd_bank (>= NUM_HIST): commands are dropped (stay IDLE, no done);
//    reads return 0 with rd_valid=1.
//  - Reset asserted mid-operation: immediate return to IDLE. A partially cleared or scanned
//    bank is left as is.
// TESTING
//  1. Reset, clear_start bank0 -> busy for 256 cycles, done pulse; read all bins -> 0.
//  2. Clear, vector of 16 lanes all =8'h05 -> hist[5]=16, others 0; pix_ready low 16 cycles.
//  3. Lanes 0..15 = 0..15, then cdf_start -> cdf[k]=k+1 for k<16, cdf[255]=16.
//  4. Preload hist[0]=16'hFFFE, then a vector with 3 lanes =0 -> hist[0]=16'hFFFF (saturated);
//     CDF of that bank -> all cdf entries = 16'hFFFF.
//  5. clear_start, cdf_start and pix_valid in the same IDLE cycle -> CLEAR only, pix_ready=0,
//     vector not consumed; bank1 untouched while bank0 is processed.
//  6. Reset low at cycle 100 of CLEAR -> busy=0, done=0, rd_valid=0 asynchronously;
//     bins 0..99 read 0 after release.

Source files
------------

// File: rtl/histogram_cdf_unit.sv
// histogram_cdf_unit: banked histogram engine that clears, fills from LANES-wide pixel vectors
// and scans each bank into a saturating running-sum CDF, with an independent registered read port.
module histogram_cdf_unit #(
    parameter int LANES    = 16,
    parameter int PIX_W    = 8,
    parameter int CNT_W    = 16,
    parameter int NUM_HIST = 2,
    parameter int BSEL_W   = (NUM_HIST > 1) ? $clog2(NUM_HIST) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [BSEL_W-1:0]      bank_sel,
    input  logic                   clear_start,
    input  logic                   cdf_start,
    input  logic                   pix_valid,
    output logic                   pix_ready,
    input  logic [LANES*PIX_W-1:0] pix_data,
    input  logic                   rd_en,
    input  logic                   rd_src,
    input  logic [BSEL_W-1:0]      rd_bank,
    input  logic [PIX_W-1:0]       rd_addr,
    output logic [CNT_W-1:0]       rd_data,
    output logic                   rd_valid,
    output logic                   busy,
    output logic                   done
);
    localparam int BINS = 1 << PIX_W;
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [BSEL_W:0] NB = (BSEL_W+1)'(NUM_HIST);
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, CDF} state_t;

    state_t                 state, state_nx;
    logic [BSEL_W-1:0]      bank, bank_nx;
    logic [PIX_W-1:0]       idx, idx_nx;
    logic [LW-1:0]          lane, lane_nx;
    logic [LANES*PIX_W-1:0] vec, vec_nx;
    logic [CNT_W-1:0]       sum, sum_nx;

    logic [CNT_W-1:0] hist [NUM_HIST][BINS];
    logic [CNT_W-1:0] cdf  [NUM_HIST][BINS];

    logic             cmd_ok, rd_ok, last_bin, last_lane;
    logic [PIX_W-1:0] lane_pix;
    logic [CNT_W-1:0] acc_old, acc_new, scan_sum;
    logic [CNT_W:0]   scan_add;
    logic             hist_we, cdf_we;
    logic [PIX_W-1:0] hist_wa;
    logic [CNT_W-1:0] hist_wd, cdf_wd;

    assign cmd_ok    = {1'b0, bank_sel} < NB;
    assign rd_ok     = {1'b0, rd_bank} < NB;
    assign last_bin  = &idx;
    assign last_lane = lane == LAST_LANE;
    assign lane_pix  = vec[lane*PIX_W +: PIX_W];
    // Registered arrays make each lane's write visible to the next lane, so duplicates accumulate
    assign acc_old   = hist[bank][lane_pix];
    assign acc_new   = &acc_old ? acc_old : acc_old + CNT_W'(1);
    assign scan_add  = {1'b0, sum} + {1'b0, hist[bank][idx]};
    assign scan_sum  = scan_add[CNT_W] ? '1 : scan_add[CNT_W-1:0];

    assign busy      = state != IDLE;
    assign pix_ready = state == IDLE && !clear_start && !cdf_start;

    always_comb begin
        state_nx = state;
        bank_nx  = bank;
        idx_nx   = idx;
        lane_nx  = lane;
        vec_nx   = vec;
        sum_nx   = sum;
        hist_we  = 1'b0;
        hist_wa  = idx;
        hist_wd  = '0;
        cdf_we   = 1'b0;
        cdf_wd   = '0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                idx_nx  = '0;
                lane_nx = '0;
                sum_nx  = '0;
                // Out-of-range bank drops the command rather than falling through to a lower priority
                if (clear_start) begin
                    if (cmd_ok) begin
                        state_nx = CLEAR;
                        bank_nx  = bank_sel;
                    end
                end else if (cdf_start) begin
                    if (cmd_ok) begin
                        state_nx = CDF;
                        bank_nx  = bank_sel;
                    end
                end else if (pix_valid && cmd_ok) begin
                    state_nx = ACCUM;
                    bank_nx  = bank_sel;
                    vec_nx   = pix_data;
                end
            end
            CLEAR: begin
                hist_we  = 1'b1;
                cdf_we   = 1'b1;
                idx_nx   = idx + PIX_W'(1);
                done     = last_bin;
                state_nx = last_bin ? IDLE : CLEAR;
            end
            ACCUM: begin
                hist_we  = 1'b1;
                hist_wa  = lane_pix;
                hist_wd  = acc_new;
                lane_nx  = lane + LW'(1);
                done     = last_lane;
                state_nx = last_lane ? IDLE : ACCUM;
            end
            CDF: begin
                cdf_we   = 1'b1;
                cdf_wd   = scan_sum;
                sum_nx   = scan_sum;
                idx_nx   = idx + PIX_W'(1);
                done     = last_bin;
                state_nx = last_bin ? IDLE : CDF;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            bank  <= '0;
            idx   <= '0;
            lane  <= '0;
            vec   <= '0;
            sum   <= '0;
        end else begin
            state <= state_nx;
            bank  <= bank_nx;
            idx   <= idx_nx;
            lane  <= lane_nx;
            vec   <= vec_nx;
            sum   <= sum_nx;
        end
    end

    // Array contents survive reset; writes are gated by the FSM state, which resets to IDLE
    always_ff @(posedge clk) begin
        if (hist_we) hist[bank][hist_wa] <= hist_wd;
        if (cdf_we) cdf[bank][idx] <= cdf_wd;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= !rd_ok ? '0 : rd_src ? cdf[rd_bank][rd_addr] : hist[rd_bank][rd_addr];
        end
    end
endmodule
